// File: rtl/ifm_pkg.sv
// ---------------------------------------------------------------------------
// ifm_pkg
// Shared definitions for the ingress FIFO receive packer:
//   - field widths of the data-FIFO word and the info byte
//   - bit positions inside the per-frame info byte
//   - packer FSM state encoding
//   - the terminator word written when a frame is truncated
//   - a saturating length accumulator helper
// ---------------------------------------------------------------------------
package ifm_pkg;

  localparam int W_DATA = 64;
  localparam int W_KEEP = 8;
  localparam int W_WORD = 73;
  localparam int W_INFO = 8;

  // Info byte bit positions
  localparam int INFO_GOOD    = 0;
  localparam int INFO_MAC_BAD = 1;
  localparam int INFO_TRUNC   = 2;
  localparam int INFO_RUNT    = 3;
  localparam int INFO_GIANT   = 4;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_PASS = 2'd2,
    ST_DROP = 2'd3
  } ifm_state_t;

  // {last=1, keep=0, data=0}: closes a frame cut short by a full FIFO
  localparam logic [W_WORD-1:0] TERM_WORD = {1'b1, 8'h00, 64'h0};

  // Frame length accumulator, saturating at 16'hFFFF
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {13'd0, b};
    if (sum[16]) begin
      return 16'hFFFF;
    end else begin
      return sum[15:0];
    end
  endfunction

endpackage

// File: rtl/ifm_keep_count.sv
// ---------------------------------------------------------------------------
// ifm_keep_count
// Combinational popcount of an 8-bit byte-enable vector.
//   keep  in  8  byte enables
//   count out 4  number of enabled bytes (0..8)
// ---------------------------------------------------------------------------
module ifm_keep_count
  import ifm_pkg::*;
(
  input  logic [W_KEEP-1:0] keep,
  output logic [3:0]        count
);

  // Sum the enable bits
  always_comb begin
    count = 4'd0;
    for (int i = 0; i < W_KEEP; i++) begin
      count = count + {3'd0, keep[i]};
    end
  end

endmodule

// File: rtl/ifm_rx_pack.sv
// ---------------------------------------------------------------------------
// ifm_rx_pack
// Packs the 10G MAC receive AXI-Stream (no back-pressure) into data-FIFO
// words {last, keep, data} and one status byte per accepted frame.
// Whole frames are dropped when the data FIFO is almost full at frame start;
// a frame that hits almost-full mid-way is closed with a terminator word.
//
// Ports:
//   rx_clk, rx_reset             clock, synchronous active-high reset
//   rx_axis_t{data,keep,valid,last,user}  MAC receive stream
//   data_fifo_wdata/wren         73-bit data FIFO write side
//   data_fifo_afull              data FIFO almost-full
//   info_fifo_wdata/wren         per-frame status byte write side
//   stat_ok/bad/drop/trunc       32-bit frame counters
//
// Build option: define IFM_RX_STATS_EN to implement the frame counters;
// without it the stat_* ports are tied to zero.
// ---------------------------------------------------------------------------
module ifm_rx_pack
  import ifm_pkg::*;
#(
  parameter int C_MIN_FRAME = 64,
  parameter int C_MAX_FRAME = 1518
) (
  input  logic              rx_clk,
  input  logic              rx_reset,
  input  logic [W_DATA-1:0] rx_axis_tdata,
  input  logic [W_KEEP-1:0] rx_axis_tkeep,
  input  logic              rx_axis_tvalid,
  input  logic              rx_axis_tlast,
  input  logic              rx_axis_tuser,
  output logic [W_WORD-1:0] data_fifo_wdata,
  output logic              data_fifo_wren,
  input  logic              data_fifo_afull,
  output logic [W_INFO-1:0] info_fifo_wdata,
  output logic              info_fifo_wren,
  output logic [31:0]       stat_ok,
  output logic [31:0]       stat_bad,
  output logic [31:0]       stat_drop,
  output logic [31:0]       stat_trunc
);

  localparam logic [15:0] MIN_LEN_C = 16'(C_MIN_FRAME);
  localparam logic [15:0] MAX_LEN_C = 16'(C_MAX_FRAME);

  ifm_state_t        state_r, state_nxt_s;
  logic [15:0]       len_r, len_nxt_s, len_sum_s;
  logic [3:0]        beat_bytes_s;
  logic [W_WORD-1:0] data_fifo_wdata_r, dword_s;
  logic              data_fifo_wren_r, dwr_s;
  logic [W_INFO-1:0] info_fifo_wdata_r, iword_s;
  logic              info_fifo_wren_r, iwr_s;
  logic              ev_drop_s, ev_trunc_s;

  ifm_keep_count u_keep_count (
    .keep  (rx_axis_tkeep),
    .count (beat_bytes_s)
  );

  assign len_sum_s = sat_add16(len_r, beat_bytes_s);

  // Status byte of a frame that completed without truncation
  function automatic logic [W_INFO-1:0] make_info(input logic user, input logic [15:0] len);
    logic [W_INFO-1:0] info;
    logic              runt;
    logic              giant;
    runt  = (len < MIN_LEN_C);
    giant = (len > MAX_LEN_C);
    info  = 8'h00;
    info[INFO_GOOD]    = user & ~runt & ~giant;
    info[INFO_MAC_BAD] = ~user;
    info[INFO_RUNT]    = runt;
    info[INFO_GIANT]   = giant;
    return info;
  endfunction

  // Next-state and write decisions for the current input beat
  always_comb begin
    state_nxt_s = state_r;
    len_nxt_s   = len_r;
    dwr_s       = 1'b0;
    dword_s     = data_fifo_wdata_r;
    iwr_s       = 1'b0;
    iword_s     = info_fifo_wdata_r;
    ev_drop_s   = 1'b0;
    ev_trunc_s  = 1'b0;
    if (rx_axis_tvalid) begin
      case (state_r)
        ST_SYNC: begin
          if (rx_axis_tlast) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_SYNC;
          end
        end
        ST_IDLE: begin
          // Single-beat frames are dropped too, so every written frame
          // takes at least two data-FIFO entries.
          if (data_fifo_afull || rx_axis_tlast) begin
            ev_drop_s = 1'b1;
            if (rx_axis_tlast) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_DROP;
            end
          end else begin
            dwr_s       = 1'b1;
            dword_s     = {1'b0, rx_axis_tkeep, rx_axis_tdata};
            len_nxt_s   = {12'd0, beat_bytes_s};
            state_nxt_s = ST_PASS;
          end
        end
        ST_PASS: begin
          if (!data_fifo_afull) begin
            dwr_s     = 1'b1;
            dword_s   = {rx_axis_tlast, rx_axis_tkeep, rx_axis_tdata};
            len_nxt_s = len_sum_s;
            if (rx_axis_tlast) begin
              iwr_s       = 1'b1;
              iword_s     = make_info(rx_axis_tuser, len_sum_s);
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_PASS;
            end
          end else begin
            // Length of a truncated frame is meaningless: report trunc only
            dwr_s      = 1'b1;
            dword_s    = TERM_WORD;
            iwr_s      = 1'b1;
            iword_s    = 8'h00;
            iword_s[INFO_TRUNC] = 1'b1;
            ev_trunc_s = 1'b1;
            if (rx_axis_tlast) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (rx_axis_tlast) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DROP;
          end
        end
        default: begin
          state_nxt_s = ST_SYNC;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state, length and registered FIFO write outputs
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state_r           <= ST_SYNC;
      len_r             <= 16'd0;
      data_fifo_wdata_r <= '0;
      data_fifo_wren_r  <= 1'b0;
      info_fifo_wdata_r <= 8'h00;
      info_fifo_wren_r  <= 1'b0;
    end else begin
      state_r           <= state_nxt_s;
      len_r             <= len_nxt_s;
      data_fifo_wdata_r <= dword_s;
      data_fifo_wren_r  <= dwr_s;
      info_fifo_wdata_r <= iword_s;
      info_fifo_wren_r  <= iwr_s;
    end
  end

  assign data_fifo_wdata = data_fifo_wdata_r;
  assign data_fifo_wren  = data_fifo_wren_r;
  assign info_fifo_wdata = info_fifo_wdata_r;
  assign info_fifo_wren  = info_fifo_wren_r;

`ifdef IFM_RX_STATS_EN
  logic [31:0] stat_ok_r, stat_bad_r, stat_drop_r, stat_trunc_r;

  // Frame counters, updated in the cycle the event is registered
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      stat_ok_r    <= 32'd0;
      stat_bad_r   <= 32'd0;
      stat_drop_r  <= 32'd0;
      stat_trunc_r <= 32'd0;
    end else begin
      if (iwr_s && iword_s[INFO_GOOD]) begin
        stat_ok_r <= stat_ok_r + 32'd1;
      end else if (iwr_s) begin
        stat_bad_r <= stat_bad_r + 32'd1;
      end else begin
        stat_ok_r <= stat_ok_r;
      end
      if (ev_drop_s) begin
        stat_drop_r <= stat_drop_r + 32'd1;
      end else begin
        stat_drop_r <= stat_drop_r;
      end
      if (ev_trunc_s) begin
        stat_trunc_r <= stat_trunc_r + 32'd1;
      end else begin
        stat_trunc_r <= stat_trunc_r;
      end
    end
  end

  assign stat_ok    = stat_ok_r;
  assign stat_bad   = stat_bad_r;
  assign stat_drop  = stat_drop_r;
  assign stat_trunc = stat_trunc_r;
`else
  logic unused_stat_s;
  assign unused_stat_s = ^{ev_drop_s, ev_trunc_s};
  assign stat_ok    = 32'd0;
  assign stat_bad   = 32'd0;
  assign stat_drop  = 32'd0;
  assign stat_trunc = 32'd0;
`endif

endmodule

// File: tb/tb_ifm_rx_pack.sv
// ---------------------------------------------------------------------------
// tb_ifm_rx_pack
// Directed self-checking bench for ifm_rx_pack. Expected counter values
// follow IFM_RX_STATS_EN (zero when the counters are not built).
// ---------------------------------------------------------------------------
module tb_ifm_rx_pack;

`ifdef IFM_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rx_reset;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;
  logic [72:0] dwdata;
  logic        dwren;
  logic        afull;
  logic [7:0]  iwdata;
  logic        iwren;
  logic [31:0] stat_ok, stat_bad, stat_drop, stat_trunc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifm_rx_pack #(.C_MIN_FRAME(64), .C_MAX_FRAME(1518)) dut (
    .rx_clk          (clk),
    .rx_reset        (rx_reset),
    .rx_axis_tdata   (tdata),
    .rx_axis_tkeep   (tkeep),
    .rx_axis_tvalid  (tvalid),
    .rx_axis_tlast   (tlast),
    .rx_axis_tuser   (tuser),
    .data_fifo_wdata (dwdata),
    .data_fifo_wren  (dwren),
    .data_fifo_afull (afull),
    .info_fifo_wdata (iwdata),
    .info_fifo_wren  (iwren),
    .stat_ok         (stat_ok),
    .stat_bad        (stat_bad),
    .stat_drop       (stat_drop),
    .stat_trunc      (stat_trunc)
  );

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat, then check the registered outputs it produced
  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                      input logic u, input logic af, input logic exp_dwr,
                      input logic [72:0] exp_dw, input logic exp_iwr,
                      input logic [7:0] exp_iw, input string tag);
    @(negedge clk);
    tdata = d; tkeep = k; tlast = l; tuser = u; afull = af; tvalid = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".dwren"}, 73'(dwren), 73'(exp_dwr));
    if (exp_dwr) chk({tag, ".dwdata"}, dwdata, exp_dw);
    chk({tag, ".iwren"}, 73'(iwren), 73'(exp_iwr));
    if (exp_iwr) chk({tag, ".iwdata"}, 73'(iwdata), 73'(exp_iw));
  endtask

  task automatic gap();
    @(negedge clk);
    tvalid = 1'b0; afull = 1'b0;
    @(posedge clk);
    #1;
    chk("gap.dwren", 73'(dwren), 73'd0);
  endtask

  function automatic logic [63:0] pat(input int fid, input int b);
    return {32'hC0DE_0000 + 32'(fid), 32'(b)};
  endfunction

  // Full frame with afull low; keep=FF except the last beat
  task automatic run_frame(input int fid, input int nb, input logic [7:0] lk,
                           input logic u, input logic wr, input logic [7:0] info,
                           input int gap_every, input string tag);
    for (int b = 1; b <= nb; b++) begin
      logic       l;
      logic [7:0] k;
      logic [63:0] d;
      if (gap_every > 0 && (b % gap_every) == 0) gap();
      l = (b == nb);
      k = l ? lk : 8'hFF;
      d = pat(fid, b);
      beat(d, k, l, u, 1'b0, wr, {l, k, d}, wr && l, info, tag);
    end
  endtask

  task automatic check_stats(input int ok, input int bad, input int drop, input int trunc);
    chk("stat_ok",    73'(stat_ok),    73'(STATS ? 32'(ok)    : 32'd0));
    chk("stat_bad",   73'(stat_bad),   73'(STATS ? 32'(bad)   : 32'd0));
    chk("stat_drop",  73'(stat_drop),  73'(STATS ? 32'(drop)  : 32'd0));
    chk("stat_trunc", 73'(stat_trunc), 73'(STATS ? 32'(trunc) : 32'd0));
  endtask

  initial begin
    rx_reset = 1'b1; tvalid = 1'b0; tdata = 64'd0; tkeep = 8'd0;
    tlast = 1'b0; tuser = 1'b0; afull = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.dwren",  73'(dwren),  73'd0);
    chk("rst.dwdata", dwdata,      73'd0);
    chk("rst.iwren",  73'(iwren),  73'd0);
    chk("rst.iwdata", 73'(iwdata), 73'd0);
    check_stats(0, 0, 0, 0);
    @(negedge clk);
    rx_reset = 1'b0;

    // First frame after reset is swallowed in SYNC
    run_frame(1, 8, 8'hFF, 1'b1, 1'b0, 8'h00, 0, "sync");
    // 64 B good frame
    run_frame(2, 8, 8'hFF, 1'b1, 1'b1, 8'h01, 0, "good64");
    check_stats(1, 0, 0, 0);
    // 60 B runt
    run_frame(3, 8, 8'h0F, 1'b1, 1'b1, 8'h08, 0, "runt60");
    // 1600 B, MAC bad -> giant + mac_bad
    run_frame(4, 200, 8'hFF, 1'b0, 1'b1, 8'h12, 0, "giant1600");
    check_stats(1, 2, 0, 0);

    // afull at frame start: whole 10-beat frame dropped
    for (int b = 1; b <= 10; b++) begin
      beat(pat(5, b), 8'hFF, b == 10, 1'b1, b == 1, 1'b0, 73'd0, 1'b0, 8'h00, "drop10");
    end
    check_stats(1, 2, 1, 0);
    // Single-beat frame dropped
    beat(pat(6, 1), 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 73'd0, 1'b0, 8'h00, "drop1");
    check_stats(1, 2, 2, 0);

    // afull on beat 4: three beats, terminator, rest discarded
    for (int b = 1; b <= 10; b++) begin
      if (b < 4)
        beat(pat(7, b), 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, {1'b0, 8'hFF, pat(7, b)}, 1'b0, 8'h00, "trunc");
      else if (b == 4)
        beat(pat(7, b), 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, {1'b1, 8'h00, 64'h0}, 1'b1, 8'h04, "trunc.term");
      else
        beat(pat(7, b), 8'hFF, b == 10, 1'b1, 1'b0, 1'b0, 73'd0, 1'b0, 8'h00, "trunc.drop");
    end
    check_stats(1, 3, 2, 1);

    // Back-to-back frames with tvalid gaps
    run_frame(8, 2, 8'hFF, 1'b1, 1'b1, 8'h08, 0, "b2b16");
    run_frame(9, 9, 8'hFF, 1'b1, 1'b1, 8'h01, 3, "b2b72");
    run_frame(10, 9, 8'h01, 1'b1, 1'b1, 8'h01, 2, "b2b65");
    check_stats(3, 4, 2, 1);

    // Reset on beat 3 of a frame
    beat(pat(11, 1), 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, {1'b0, 8'hFF, pat(11, 1)}, 1'b0, 8'h00, "mrst");
    beat(pat(11, 2), 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, {1'b0, 8'hFF, pat(11, 2)}, 1'b0, 8'h00, "mrst");
    @(negedge clk);
    tdata = pat(11, 3); tkeep = 8'hFF; tlast = 1'b0; tvalid = 1'b1; rx_reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst.dwren",  73'(dwren),  73'd0);
    chk("mrst.dwdata", dwdata,      73'd0);
    chk("mrst.iwren",  73'(iwren),  73'd0);
    chk("mrst.iwdata", 73'(iwdata), 73'd0);
    check_stats(0, 0, 0, 0);
    @(negedge clk);
    rx_reset = 1'b0;
    for (int b = 4; b <= 8; b++) begin
      beat(pat(11, b), 8'hFF, b == 8, 1'b1, 1'b0, 1'b0, 73'd0, 1'b0, 8'h00, "mrst.sync");
    end
    run_frame(12, 8, 8'hFF, 1'b1, 1'b1, 8'h01, 0, "post_rst");
    check_stats(1, 0, 0, 0);

    @(negedge clk);
    tvalid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifm_rx_pack.md
# ifm_rx_pack

Receive-side packer in the rx_clk domain that sits between the 10G MAC receive AXI-Stream and the ingress FIFO block. Each MAC beat becomes a 73-bit data-FIFO word {last, keep[7:0], data[63:0]}, and each accepted frame produces one 8-bit status byte in the info FIFO. The block drops whole frames when the data FIFO is almost full at frame start. If the FIFO fills mid-frame, the frame is truncated with a terminator word, because the MAC cannot be back-pressured.

## Interface
Parameters:
- C_MIN_FRAME, 64: frames shorter than this many bytes are flagged runt.
- C_MAX_FRAME, 1518: frames longer than this many bytes are flagged giant.

Ports:
- rx_clk  in  1  sole clock.
- rx_reset  in  1  synchronous, active-high reset.
- rx_axis_tdata  in  64  MAC receive data.
- rx_axis_tkeep  in  8  byte enables; contiguous from bit 0.
- rx_axis_tvalid  in  1  beat valid; there is no tready, so every valid beat is consumed.
- rx_axis_tlast  in  1  last beat of frame.
- rx_axis_tuser  in  1  MAC good-frame flag; meaningful only with tlast.
- data_fifo_wdata  out  73  {last, keep, data}.
- data_fifo_wren  out  1  data FIFO write strobe.
- data_fifo_afull  in  1  data FIFO programmable-full flag, synchronous to rx_clk.
- info_fifo_wdata  out  8  per-frame status byte.
- info_fifo_wren  out  1  info FIFO write strobe.
- stat_ok, stat_bad, stat_drop, stat_trunc  out  32 each  frame counters (see Configuration).

## Operation
- FSM states: SYNC (reset state), IDLE, PASS, DROP.
- SYNC: discards all beats. A valid beat with tlast moves to IDLE. The first frame after reset is therefore always lost, even if reset fell between frames.
- IDLE, on a valid beat:
  - afull=1, or tlast=1 (single-beat frame, at most 8 B): write nothing; stat_drop++. Stay in IDLE if tlast, otherwise go to DROP.
  - otherwise: write the beat, load len = popcount(tkeep), go to PASS.
- PASS, on a valid beat:
  - afull=0: write the beat and add popcount(tkeep) to len. On tlast, write info and go to IDLE.
  - afull=1: write the terminator {1, 8'h00, 64'h0} instead of the beat, write info with trunc=1, stat_trunc++. Go to IDLE if tlast, otherwise DROP.
- DROP: discard beats; tlast moves to IDLE. No info write and no counter change on that exit.
- Info byte layout:
  - [0] good = tuser & !runt & !giant & !trunc
  - [1] mac_bad = !tuser (always 0 when trunc)
  - [2] trunc
  - [3] runt = len < C_MIN_FRAME
  - [4] giant = len > C_MAX_FRAME
  - [7:5] = 0
- Counter update on each info write: stat_ok++ if good, otherwise stat_bad++.
- len is 16 bits and saturates at 16'hFFFF.
- Every written frame occupies at least 2 data-FIFO entries, so a 512-entry data FIFO never holds more than 256 frames and the 256-deep info FIFO cannot overflow.
- Counters wrap modulo 2^32.

## Timing
- One-stage output pipeline: an input beat at cycle N appears as a data write at N+1.
- The info write is in the same cycle as the data write carrying last=1.
- afull is sampled in the same cycle as the beat it governs. The FIFO threshold must leave at least 2 entries of headroom.
- Gaps in tvalid are allowed anywhere; state is held across them.
- Reset values: all wren=0, all wdata=0, all stat_*=0, FSM=SYNC, len=0.
- Reset asserted mid-frame aborts the frame with no terminator. The consumer relies on the SYNC rule plus its own reset, which is the same reset.

## Configuration
- IFM_RX_STATS_EN defined: the four 32-bit counters are implemented as specified.
- Not defined: the stat_* ports remain and are tied to 0; no counter flops are generated.

## Structure
- Package ifm_pkg holds:
  - info-byte bit indices
  - FSM state encoding
  - the 73-bit terminator constant
  - field widths: data 64, keep 8, word 73, info 8
- Sub-module ifm_keep_count: combinational 8-bit tkeep to 4-bit byte-count popcount, used for len.

## Test plan
- After reset, a 64 B frame (8 beats) is discarded in SYNC. The next 64 B frame with tuser=1 gives 8 data writes, last on beat 8, and info 8'h01; stat_ok=1.
- 60 B frame (last beat keep 8'h0F) with tuser=1 gives info 8'h08; a 1600 B frame with tuser=0 gives info 8'h12. stat_bad=2.
- afull=1 on the first beat of a 10-beat frame gives no writes, stat_drop=1, and the FSM back in IDLE after tlast. A single-beat frame also gives stat_drop++ with no writes.
- afull rises on beat 4 of a 10-beat frame: beats 1–3 are written, then the terminator; info is 8'h04; beats 5–10 are discarded; stat_trunc=1.
- Back-to-back frames with no idle cycle, plus random tvalid gaps, give a byte-exact match against a reference model. Reset asserted on beat 3 gives all outputs 0 on the next cycle and SYNC behaviour afterwards.
- With IFM_RX_STATS_EN undefined, the first scenario still passes on data and info, and all stat_* ports stay 0.
